// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op codes, FSM states and the per-lane evaluator shared by the logic unit
package logic_unit_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;
  typedef enum logic {IDLE, ACC} state_e;
  // One bit lane; lanes never interact, so the datapath is built from copies of this.
  function automatic logic logic_eval(input op_e op, input logic x, input logic y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NAND: return ~(x & y);
      OP_NOR:  return ~(x | y);
      OP_XNOR: return ~(x ^ y);
      OP_ANDN: return x & ~y;
      default: return x;
    endcase
  endfunction
endpackage

// File: rtl/logic_op_eval.sv
// logic_op_eval: combinational WIDTH-bit bitwise evaluator
module logic_op_eval
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] res_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign res_o[i] = logic_eval(op_i, x_i[i], y_i[i]);
  end
endmodule

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: pipelined bitwise logic unit with valid/ready handshake and packet accumulation
module bitwise_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, single_res, acc_res;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d, cnt_sat;
  logic             out_valid_q, out_valid_d, err_q, err_d, fire, emit;
  logic_op_eval #(.WIDTH(WIDTH)) u_single (.op_i(op_e'(in_op)), .x_i(in_a), .y_i(in_b), .res_o(single_res));
  logic_op_eval #(.WIDTH(WIDTH)) u_acc (.op_i(op_e'(in_op)), .x_i(acc_q), .y_i(in_a), .res_o(acc_res));
  assign in_ready = !out_valid_q | out_ready;
  assign fire     = in_valid & in_ready;
  assign emit     = fire & (!in_acc | in_last);
  assign cnt_sat  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (fire && in_acc) state_d = in_last ? IDLE : ACC;
  end
  // Single beats bypass the accumulator entirely, so a mismatched beat leaves the packet intact.
  always_comb begin
    acc_d       = !(fire & in_acc) ? acc_q : (state_q == IDLE) ? in_a : acc_res;
    cnt_d       = !(fire & in_acc) ? cnt_q : (state_q == IDLE) ? CNT_ONE : cnt_sat;
    out_data_d  = !emit ? out_data_q : in_acc ? acc_d : single_res;
    out_cnt_d   = !emit ? out_cnt_q : in_acc ? cnt_d : CNT_ONE;
    out_valid_d = emit | (out_valid_q & !out_ready);
    err_d       = err_q | (fire & !in_acc & (state_q == ACC));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign err       = err_q;
endmodule
